csr: RTL and testbench

Machine-mode CSR unit for the RV32 core, sitting directly downstream of the EX stage on the `EX2CSR`/`CSR2EX` link. Executes CSRRW/CSRRS/CSRRC (and immediate forms, already resolved by EX into `rs1_rdata`), owns the 64-bit cycle/instret counters, and handles machine external/timer interrupts, MRET and WFI sleep. Produces redirect requests for IF and a stall for the pipeline while sleeping.

---
 rtl/csr.sv | 162 ++++++++++++++++
 tb/tb_csr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr.sv
// Machine-mode CSR unit: CSR read/modify/write, 64-bit cycle/instret counters,
// external/timer interrupt entry, MRET and WFI sleep with pipeline stall.
module csr #(
    parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] pc,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_rdata,
    input  logic        reg_wr,
    input  logic        wr,
    input  logic        set,
    input  logic        clr,
    input  logic        mret,
    input  logic        wfi,
    input  logic        retire,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] rd_wdata,
    output logic        trap_valid,
    output logic [31:0] trap_pc,
    output logic        ret_valid,
    output logic [31:0] ret_pc,
    output logic        stall
);
    typedef enum logic {RUN, SLEEP} state_t;

    state_t      state_reg, state_next;
    logic        mstatus_mie_reg, mstatus_mpie_reg;
    logic        mie_mtie_reg, mie_meie_reg;
    logic        mip_mtip_reg, mip_meip_reg;
    logic [31:2] mtvec_reg, mepc_reg, wfi_pc_reg;

    logic [31:0] mstatus_val, mie_val, mip_val, old_val, new_val;
    logic [63:0] mcycle, minstret;
    logic        pending, take, cmd_active, csr_write, do_ret;

    assign mstatus_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_reg, 3'd0, mstatus_mie_reg, 3'd0};
    assign mie_val     = {20'd0, mie_meie_reg, 3'd0, mie_mtie_reg, 7'd0};
    assign mip_val     = {20'd0, mip_meip_reg, 3'd0, mip_mtip_reg, 7'd0};

    assign pending = (mip_mtip_reg & mie_mtie_reg) | (mip_meip_reg & mie_meie_reg);
    assign take    = mstatus_mie_reg & pending & ((state_reg == RUN) ? ex_valid : 1'b1);

    // Commands only execute in RUN; an interrupted instruction is replayed after return.
    assign cmd_active = ex_valid & (state_reg == RUN) & ~take;
    assign csr_write  = cmd_active & (wr | ((set | clr) & (|rs1_rdata)));
    assign do_ret     = cmd_active & mret;

    always_comb begin
        old_val = 32'd0;
        case (csr_addr)
            12'h300:          old_val = mstatus_val;
            12'h304:          old_val = mie_val;
            12'h305:          old_val = {mtvec_reg, 2'b00};
            12'h341:          old_val = {mepc_reg, 2'b00};
            12'h344:          old_val = mip_val;
            12'hB00, 12'hC00: old_val = mcycle[31:0];
            12'hB80, 12'hC80: old_val = mcycle[63:32];
            12'hB02, 12'hC02: old_val = minstret[31:0];
            12'hB82, 12'hC82: old_val = minstret[63:32];
            default:          old_val = 32'd0;
        endcase
    end

    always_comb begin
        new_val = old_val & ~rs1_rdata;
        if (wr)
            new_val = rs1_rdata;
        else if (set)
            new_val = old_val | rs1_rdata;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (cmd_active && wfi) state_next = SLEEP;
            SLEEP:   if (pending) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Pulses are masked during reset so nothing escapes in the reset cycle.
    assign rd_wdata   = (!rst && ex_valid && reg_wr) ? old_val : 32'd0;
    assign trap_valid = ~rst & take;
    assign trap_pc    = {mtvec_reg, 2'b00};
    assign ret_valid  = ~rst & do_ret;
    assign ret_pc     = {mepc_reg, 2'b00};
    assign stall      = ~rst & (state_reg == SLEEP) & ~pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= RUN;
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_mtie_reg     <= 1'b0;
            mie_meie_reg     <= 1'b0;
            mip_mtip_reg     <= 1'b0;
            mip_meip_reg     <= 1'b0;
            mtvec_reg        <= MTVEC_RST[31:2];
            mepc_reg         <= 30'd0;
            wfi_pc_reg       <= 30'd0;
        end else begin
            state_reg    <= state_next;
            mip_mtip_reg <= timer_irq;
            mip_meip_reg <= ext_irq;
            if (take) begin
                mepc_reg         <= (state_reg == RUN) ? pc[31:2] : wfi_pc_reg;
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (do_ret) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (csr_write && csr_addr == 12'h300) begin
                mstatus_mie_reg  <= new_val[3];
                mstatus_mpie_reg <= new_val[7];
            end
            if (cmd_active && wfi)
                wfi_pc_reg <= pc[31:2] + 30'd1;
            if (csr_write && csr_addr == 12'h304) begin
                mie_mtie_reg <= new_val[7];
                mie_meie_reg <= new_val[11];
            end
            if (csr_write && csr_addr == 12'h305)
                mtvec_reg <= new_val[31:2];
            if (csr_write && csr_addr == 12'h341)
                mepc_reg <= new_val[31:2];
        end
    end

    // Counter 0 = mcycle, counter 1 = minstret; a write to either half freezes the other half.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_cnt
            localparam logic [11:0] LO_ADDR = (gi == 0) ? 12'hB00 : 12'hB02;
            localparam logic [11:0] HI_ADDR = LO_ADDR | 12'h080;
            logic [63:0] count_reg, count_next, inc;

            assign inc = (gi == 0) ? 64'd1 : {63'd0, retire};

            always_comb begin
                count_next = count_reg + inc;
                if (csr_write && csr_addr == LO_ADDR)
                    count_next = {count_reg[63:32], new_val};
                else if (csr_write && csr_addr == HI_ADDR)
                    count_next = {new_val, count_reg[31:0]};
            end

            always_ff @(posedge clk) begin
                if (rst)
                    count_reg <= 64'd0;
                else
                    count_reg <= count_next;
            end
        end
    endgenerate

    assign mcycle   = gen_cnt[0].count_reg;
    assign minstret = gen_cnt[1].count_reg;
endmodule

// File: tb/tb_csr.sv
// Scoreboard bench for csr: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_csr;
    logic        clk = 1'b0;
    logic        rst, ex_valid, reg_wr, wr, set, clr, mret, wfi, retire, ext_irq, timer_irq;
    logic [31:0] pc, rs1_rdata, rd_wdata, trap_pc, ret_pc;
    logic [11:0] csr_addr;
    logic        trap_valid, ret_valid, stall;

    always #5 clk = ~clk;

    csr dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .pc(pc), .csr_addr(csr_addr),
        .rs1_rdata(rs1_rdata), .reg_wr(reg_wr), .wr(wr), .set(set), .clr(clr),
        .mret(mret), .wfi(wfi), .retire(retire), .ext_irq(ext_irq), .timer_irq(timer_irq),
        .rd_wdata(rd_wdata), .trap_valid(trap_valid), .trap_pc(trap_pc),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .stall(stall)
    );

    typedef struct {
        int         id;
        logic [31:0] rd;
        logic        tv;
        logic [31:0] tpc;
        logic        rv;
        logic [31:0] rpc;
        logic        st;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, n_txn = 0;

    // Architectural model: whole CSR words plus 64-bit counters.
    bit [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mip, m_wfi_pc;
    bit [63:0] m_cyc, m_inst;
    bit        m_sleep;
    bit [31:0] pc_q = 32'h200;
    bit        cur_ei = 0, cur_ti = 0;

    function automatic bit [31:0] m_read(input bit [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h344: return m_mip;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_inst[31:0];
            12'hB82, 12'hC82: return m_inst[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 32'h0001_0000; m_mepc = 0;
        m_mip = 0; m_wfi_pc = 0; m_cyc = 0; m_inst = 0; m_sleep = 0;
    endtask

    // op: 0 none, 1 CSRRW, 2 CSRRS, 3 CSRRC
    task automatic issue(input bit r, input bit ev, input bit [31:0] p, input bit [11:0] a,
                         input bit [31:0] v, input bit rw, input bit [1:0] op, input bit mr,
                         input bit wf, input bit rt, input bit ei, input bit ti, input bit push);
        exp_t e;
        bit pend, take, exec;
        bit [31:0] mst_n, mie_n, mtvec_n, mepc_n, wfi_n, oldv, nv;
        bit [63:0] cyc_n, inst_n;
        bit sleep_n;
        @(posedge clk);
        #1;
        rst = r; ex_valid = ev; pc = p; csr_addr = a; rs1_rdata = v; reg_wr = rw;
        wr = (op == 1); set = (op == 2); clr = (op == 3); mret = mr; wfi = wf;
        retire = rt; ext_irq = ei; timer_irq = ti;
        e.id = n_txn; n_txn++;
        e.tpc = m_mtvec; e.rpc = m_mepc;
        if (r) begin
            e.rd = 0; e.tv = 0; e.rv = 0; e.st = 0;
            m_reset();
        end else begin
            pend = (m_mip & m_mie) != 0;
            take = m_mstatus[3] && pend && (m_sleep || ev);
            exec = ev && !m_sleep && !take;
            e.rd = (ev && rw) ? m_read(a) : 32'd0;
            e.tv = take;
            e.rv = exec && mr;
            e.st = m_sleep && !pend;
            mst_n = m_mstatus; mie_n = m_mie; mtvec_n = m_mtvec; mepc_n = m_mepc;
            wfi_n = m_wfi_pc; sleep_n = m_sleep;
            cyc_n = m_cyc + 1; inst_n = m_inst + 64'(rt);
            if (take) begin
                mepc_n = (m_sleep ? m_wfi_pc : p) & ~32'h3;
                mst_n  = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            end
            if (m_sleep && pend) sleep_n = 0;
            if (exec && mr) mst_n = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            if (exec && wf) begin sleep_n = 1; wfi_n = p + 4; end
            if (exec && (op == 1 || (op >= 2 && v != 0))) begin
                oldv = m_read(a);
                nv = (op == 1) ? v : (op == 2) ? (oldv | v) : (oldv & ~v);
                case (a)
                    12'h300: mst_n   = (nv & 32'h88) | 32'h1800;
                    12'h304: mie_n   = nv & 32'h880;
                    12'h305: mtvec_n = nv & ~32'h3;
                    12'h341: mepc_n  = nv & ~32'h3;
                    12'hB00: cyc_n   = {m_cyc[63:32], nv};
                    12'hB80: cyc_n   = {nv, m_cyc[31:0]};
                    12'hB02: inst_n  = {m_inst[63:32], nv};
                    12'hB82: inst_n  = {nv, m_inst[31:0]};
                    default: ;
                endcase
            end
            m_mstatus = mst_n; m_mie = mie_n; m_mtvec = mtvec_n; m_mepc = mepc_n;
            m_wfi_pc = wfi_n; m_sleep = sleep_n; m_cyc = cyc_n; m_inst = inst_n;
            m_mip = (ei ? 32'h800 : 32'h0) | (ti ? 32'h80 : 32'h0);
        end
        if (push) sb.push_back(e);
    endtask

    task automatic csr_op(input bit [1:0] op, input bit [11:0] a, input bit [31:0] v);
        issue(0, 1, pc_q, a, v, 1, op, 0, 0, 1, cur_ei, cur_ti, 1);
        pc_q += 4;
    endtask

    task automatic instr(input bit mr, input bit wf, input bit [31:0] p);
        issue(0, 1, p, 12'h000, 0, 0, 0, mr, wf, 1, cur_ei, cur_ti, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            issue(0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, cur_ei, cur_ti, 1);
    endtask

    task automatic do_reset();
        issue(1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cur_ei = 0; cur_ti = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (rd_wdata !== e.rd || trap_valid !== e.tv || trap_pc !== e.tpc ||
                ret_valid !== e.rv || ret_pc !== e.rpc || stall !== e.st) begin
                n_bad++;
                $display("FAIL txn %0d outputs: got rd=%h trap=%b/%h ret=%b/%h stall=%b, want rd=%h trap=%b/%h ret=%b/%h stall=%b",
                         e.id, rd_wdata, trap_valid, trap_pc, ret_valid, ret_pc, stall,
                         e.rd, e.tv, e.tpc, e.rv, e.rpc, e.st);
            end else begin
                $display("txn %0d ok: rd=%h trap=%b/%h ret=%b/%h stall=%b",
                         e.id, rd_wdata, trap_valid, trap_pc, ret_valid, ret_pc, stall);
            end
        end
    end

    bit [11:0] addr_tab [16] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344, 12'hB00, 12'hB80,
                                 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0,
                                 12'h300, 12'h304};

    initial begin
        m_reset();
        issue(1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // DUT state unknown before this edge
        do_reset();

        // mtvec write then read back with low bits masked
        csr_op(1, 12'h305, 32'h8000_0003);
        csr_op(2, 12'h305, 32'h0);

        // external interrupt entry
        csr_op(1, 12'h304, 32'h800);
        csr_op(1, 12'h300, 32'h8);
        cur_ei = 1; instr(0, 0, 32'h400);
        cur_ei = 0; instr(0, 0, 32'h404);
        csr_op(2, 12'h300, 0);
        csr_op(2, 12'h341, 0);
        instr(1, 0, 32'h500);            // MRET
        csr_op(2, 12'h300, 0);

        // WFI with MIE=0: wakes without trap
        csr_op(3, 12'h300, 32'h8);
        csr_op(1, 12'h304, 32'h80);
        instr(0, 1, 32'h100);
        idle(5);
        cur_ti = 1; idle(2);
        cur_ti = 0; idle(3);
        // WFI with MIE=1: wakes with trap, mepc = wfi pc + 4
        csr_op(2, 12'h300, 32'h8);
        instr(0, 1, 32'h100);
        idle(4);
        cur_ti = 1; idle(2);
        cur_ti = 0; idle(2);
        csr_op(2, 12'h341, 0);

        // counter carry and write override
        csr_op(1, 12'hB00, 32'hFFFF_FFFF);
        csr_op(1, 12'hB80, 32'h0);
        csr_op(2, 12'hB80, 0);
        csr_op(2, 12'hB00, 0);
        csr_op(2, 12'hC80, 0);
        csr_op(1, 12'hB02, 32'h0);
        for (int k = 0; k < 6; k++)
            issue(0, 0, 0, 12'h000, 0, 0, 0, 0, 0, k[0], 0, 0, 1);
        csr_op(2, 12'hB02, 0);
        csr_op(2, 12'hC02, 0);

        // unimplemented read, read-only write
        csr_op(1, 12'h7C0, 32'h1234_5678);
        csr_op(2, 12'h7C0, 0);
        csr_op(1, 12'hC00, 32'h0);
        csr_op(2, 12'hC00, 0);
        csr_op(1, 12'h344, 32'hFFFF_FFFF);

        // reset while sleeping
        csr_op(1, 12'h304, 32'h80);
        instr(0, 1, 32'h300);
        idle(3);
        do_reset();
        idle(2);
        csr_op(2, 12'h304, 0);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            bit ei, ti, r;
            int kind;
            ei = ($urandom_range(0, 7) == 0);
            ti = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 99) == 0);
            if (m_sleep) begin
                issue(r, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, ei, ti, 1);
            end else begin
                kind = $urandom_range(0, 19);
                if (r) begin
                    issue(1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, ei, ti, 1);
                end else if (kind < 12) begin
                    bit [31:0] v;
                    v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    issue(0, 1, {$urandom_range(0, 1023), 2'b00}, addr_tab[$urandom_range(0, 15)],
                          v, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0, 0,
                          $urandom_range(0, 1), ei, ti, 1);
                end else if (kind == 12) begin
                    issue(0, 1, 32'h600, 12'h000, 0, 0, 0, 1, 0, 1, ei, ti, 1);
                end else if (kind == 13 && m_mie != 0) begin
                    issue(0, 1, {$urandom_range(0, 1023), 2'b00}, 12'h000, 0, 0, 0, 0, 1, 1, ei, ti, 1);
                end else begin
                    issue(0, $urandom_range(0, 1), 32'h700, 12'h000, 0, 0, 0, 0, 0,
                          $urandom_range(0, 1), ei, ti, 1);
                end
            end
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
